dbus_access_ctrl: RTL and testbench



---
 rtl/dbus_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_dbus_access_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_access_ctrl.sv
// Data-bus handshake controller: registers an aligned load/store, holds it on the
// bus until data_ok, returns the raw response and stalls the pipeline meanwhile.
module dbus_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [63:0]      req_addr,
  input  logic [2:0]       req_size,
  input  logic [7:0]       req_strobe,
  input  logic [63:0]      req_data,
  input  logic             advance,
  input  logic             flush,
  output logic             dbus_valid,
  output logic [63:0]      dbus_addr,
  output logic [2:0]       dbus_size,
  output logic [7:0]       dbus_strobe,
  output logic [63:0]      dbus_data,
  input  logic             dbus_addr_ok,
  input  logic             dbus_data_ok,
  input  logic [63:0]      dbus_rdata,
  output logic             resp_valid,
  output logic [63:0]      resp_data,
  output logic             stall,
  output logic             misalign,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [7:0]       strobe_q, strobe_d;
  logic [63:0]      data_q, data_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic             drop_q, drop_d;
  logic             aligned;
  logic             accept;

  // Address-accept is purely informational for this controller.
  logic unused_addr_ok;
  assign unused_addr_ok = dbus_addr_ok;

  always_comb begin
    case (req_size)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = (req_addr[0] == 1'b0);
      3'd2:    aligned = (req_addr[1:0] == 2'b00);
      3'd3:    aligned = (req_addr[2:0] == 3'b000);
      default: aligned = 1'b0;
    endcase
  end

  assign accept = (state_q == IDLE) && req_valid && aligned && !flush;

  always_comb begin
    // NOTE: every next-state signal starts from its held value so no path infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    strobe_d    = strobe_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    drop_d      = drop_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = req_addr;
          size_d     = req_size;
          strobe_d   = req_strobe;
          data_d     = req_data;
          wait_cnt_d = '0;
          drop_d     = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
        if (flush) drop_d = 1'b1;
        if (dbus_data_ok) begin
          resp_data_d = (strobe_q == 8'h00) ? dbus_rdata : 64'h0;
          // A flush seen now or earlier means the pipeline no longer wants the result.
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (advance || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      strobe_q    <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      strobe_q    <= strobe_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      drop_q      <= drop_d;
    end
  end

  assign dbus_valid  = (state_q == REQ);
  assign dbus_addr   = addr_q;
  assign dbus_size   = size_q;
  assign dbus_strobe = strobe_q;
  assign dbus_data   = data_q;
  assign resp_valid  = (state_q == DONE);
  assign resp_data   = resp_data_q;
  assign bus_timeout = timeout_q;
  assign wait_cnt    = wait_cnt_q;
  assign misalign    = (state_q == IDLE) && req_valid && !aligned;
  assign stall       = accept || (state_q == REQ);

endmodule

// File: tb/tb_dbus_access_ctrl.sv
// Self-checking bench for dbus_access_ctrl: alignment vector table plus scripted
// bus transactions with a response scoreboard.
module tb_dbus_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        advance;
  logic        flush;
  logic        dbus_valid;
  logic [63:0] dbus_addr;
  logic [2:0]  dbus_size;
  logic [7:0]  dbus_strobe;
  logic [63:0] dbus_data;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic [63:0] dbus_rdata;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        stall;
  logic        misalign;
  logic        bus_timeout;
  logic [15:0] wait_cnt;

  int checks = 0;
  int errors = 0;
  int stall_cyc;
  logic [63:0] sb_q[$];

  typedef struct {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic        flush;
    logic        exp_mis;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[12];

  dbus_access_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
    .req_strobe(req_strobe), .req_data(req_data),
    .advance(advance), .flush(flush),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_size(dbus_size),
    .dbus_strobe(dbus_strobe), .dbus_data(dbus_data),
    .dbus_addr_ok(dbus_addr_ok), .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
    .misalign(misalign), .bus_timeout(bus_timeout), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: response seen with empty scoreboard, got %h", name, resp_data);
    end else begin
      exp = sb_q.pop_front();
      check(name, resp_data, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [63:0] a, input logic [2:0] s,
                           input logic [7:0] st, input logic [63:0] d);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = s;
    req_strobe = st;
    req_data   = d;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 64'h8000_0003, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 64'h8000_0001, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 64'h8000_0002, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 64'h8000_0002, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 64'h8000_0004, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 64'h8000_0004, 3'd3, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 64'h8000_0008, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 64'h8000_0000, 3'd4, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 64'h8000_0000, 3'd7, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 64'h8000_0008, 3'd3, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 64'h8000_0003, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 64'h8000_0003, 3'd1, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; req_valid = 0; req_addr = 0; req_size = 0; req_strobe = 0; req_data = 0;
    advance = 0; flush = 0; dbus_addr_ok = 0; dbus_data_ok = 0; dbus_rdata = 0;
    tick(); tick();
    reset = 1'b0;
    sample();
    check("rst_dbus_valid", dbus_valid, 0);
    check("rst_dbus_addr", dbus_addr, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_stall", stall, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    check("rst_timeout", bus_timeout, 0);

    // Alignment table: request is withdrawn before the next edge so none is accepted.
    for (int i = 0; i < 12; i++) begin
      tick();
      req_valid = vecs[i].valid; req_addr = vecs[i].addr;
      req_size = vecs[i].size;   flush = vecs[i].flush;
      #2;
      check($sformatf("vec%0d_misalign", i), misalign, vecs[i].exp_mis);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_dbus_valid", i), dbus_valid, 0);
      req_valid = 0; flush = 0;
    end

    // Aligned LD, data_ok in the 3rd REQ cycle.
    tick();
    drive_req(64'h8000_0010, 3'd3, 8'h00, 64'h0);
    sample();
    check("ld_accept_stall", stall, 1);
    check("ld_accept_dbus_valid", dbus_valid, 0);
    stall_cyc = int'(stall);
    sb_q.push_back(64'h1122_3344_5566_7788);
    for (int k = 1; k <= 3; k++) begin
      tick();
      req_valid = 0;
      if (k == 3) begin dbus_data_ok = 1; dbus_rdata = 64'h1122_3344_5566_7788; end
      sample();
      check($sformatf("ld_req%0d_valid", k), dbus_valid, 1);
      check($sformatf("ld_req%0d_addr", k), dbus_addr, 64'h8000_0010);
      check($sformatf("ld_req%0d_size", k), dbus_size, 3);
      check($sformatf("ld_req%0d_wait", k), wait_cnt, k - 1);
      stall_cyc += int'(stall);
    end
    tick();
    dbus_data_ok = 0; dbus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    check("ld_done_dbus_valid", dbus_valid, 0);
    check("ld_done_resp_valid", resp_valid, 1);
    sb_pop("ld_resp_data");
    check("ld_wait_final", wait_cnt, 3);
    stall_cyc += int'(stall);
    check("ld_stall_cycles", stall_cyc, 4);

    // DONE hold with a competing request present.
    drive_req(64'h8000_0040, 3'd3, 8'h00, 64'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      sample();
      check($sformatf("hold%0d_resp_valid", k), resp_valid, 1);
      check($sformatf("hold%0d_resp_data", k), resp_data, 64'h1122_3344_5566_7788);
      check($sformatf("hold%0d_dbus_valid", k), dbus_valid, 0);
      check($sformatf("hold%0d_stall", k), stall, 0);
    end
    req_valid = 0; advance = 1;
    tick();
    advance = 0;
    sample();
    check("adv_resp_valid", resp_valid, 0);
    check("adv_dbus_valid", dbus_valid, 0);

    // SW with zero-wait bus; leave DONE through flush.
    tick();
    drive_req(64'h8000_0004, 3'd2, 8'hF0, 64'hAABB_CCDD_0000_0000);
    sample();
    check("sw_accept_stall", stall, 1);
    sb_q.push_back(64'h0);
    tick();
    req_valid = 0; dbus_data_ok = 1; dbus_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    sample();
    check("sw_req_valid", dbus_valid, 1);
    check("sw_req_strobe", dbus_strobe, 8'hF0);
    check("sw_req_data", dbus_data, 64'hAABB_CCDD_0000_0000);
    check("sw_req_stall", stall, 1);
    tick();
    dbus_data_ok = 0;
    sample();
    check("sw_resp_valid", resp_valid, 1);
    sb_pop("sw_resp_data");
    check("sw_done_stall", stall, 0);
    check("sw_done_dbus_valid", dbus_valid, 0);
    flush = 1;
    tick();
    flush = 0;
    sample();
    check("sw_flush_exit", resp_valid, 0);

    // Misaligned LH held for several cycles.
    tick();
    drive_req(64'h8000_0003, 3'd1, 8'h00, 64'h0);
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("mis%0d_misalign", k), misalign, 1);
      check($sformatf("mis%0d_dbus_valid", k), dbus_valid, 0);
      check($sformatf("mis%0d_stall", k), stall, 0);
      tick();
    end
    req_valid = 0;
    sample();
    check("mis_after_dbus_valid", dbus_valid, 0);

    // Flush on the 2nd wait cycle, data_ok two cycles later.
    tick();
    drive_req(64'h8000_0020, 3'd3, 8'h00, 64'h0);
    sample();
    tick();
    req_valid = 0;
    sample();
    check("fl_req1_valid", dbus_valid, 1);
    tick();
    flush = 1;
    sample();
    check("fl_req2_valid", dbus_valid, 1);
    check("fl_req2_stall", stall, 1);
    tick();
    flush = 0;
    sample();
    check("fl_req3_valid", dbus_valid, 1);
    check("fl_req3_stall", stall, 1);
    tick();
    dbus_data_ok = 1; dbus_rdata = 64'h5555_AAAA_5555_AAAA;
    sample();
    check("fl_req4_valid", dbus_valid, 1);
    tick();
    dbus_data_ok = 0;
    sample();
    check("fl_end_dbus_valid", dbus_valid, 0);
    check("fl_end_resp_valid", resp_valid, 0);
    check("fl_end_stall", stall, 0);
    tick();
    sample();
    check("fl_idle_resp_valid", resp_valid, 0);
    check("fl_sb_empty", sb_q.size(), 0);

    // Flush and data_ok together, then a clean load to confirm the drop flag cleared.
    tick();
    drive_req(64'h8000_0028, 3'd3, 8'h00, 64'h0);
    sample();
    tick();
    req_valid = 0; flush = 1; dbus_data_ok = 1; dbus_rdata = 64'h1;
    sample();
    check("sim_req_valid", dbus_valid, 1);
    tick();
    flush = 0; dbus_data_ok = 0;
    sample();
    check("sim_resp_valid", resp_valid, 0);
    check("sim_dbus_valid", dbus_valid, 0);
    drive_req(64'h8000_0031, 3'd0, 8'h00, 64'h0);
    sb_q.push_back(64'h0123_4567_89AB_CDEF);
    tick();
    req_valid = 0; dbus_data_ok = 1; dbus_rdata = 64'h0123_4567_89AB_CDEF;
    sample();
    check("post_req_addr", dbus_addr, 64'h8000_0031);
    tick();
    dbus_data_ok = 0;
    sample();
    check("post_resp_valid", resp_valid, 1);
    sb_pop("post_resp_data");
    advance = 1;
    tick();
    advance = 0;

    // Watchdog: no data_ok; flag rises after the 8th REQ cycle.
    drive_req(64'h8000_0038, 3'd3, 8'h00, 64'h0);
    sample();
    for (int k = 1; k <= 8; k++) begin
      tick();
      req_valid = 0;
      sample();
      check($sformatf("to_req%0d_timeout", k), bus_timeout, 0);
      check($sformatf("to_req%0d_wait", k), wait_cnt, k - 1);
      check($sformatf("to_req%0d_valid", k), dbus_valid, 1);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      sample();
      check($sformatf("to_set%0d", k), bus_timeout, 1);
    end
    reset = 1;
    tick();
    sample();
    check("rst2_dbus_valid", dbus_valid, 0);
    check("rst2_timeout", bus_timeout, 0);
    check("rst2_wait_cnt", wait_cnt, 0);
    check("rst2_dbus_addr", dbus_addr, 0);
    check("rst2_stall", stall, 0);
    reset = 0;
    tick();
    sample();
    check("rst2_idle_dbus_valid", dbus_valid, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
